sram_march_bist: RTL and testbench
==================================

# sram_march_bist

Built-in self-test controller for the 1024x8 single-port SRAM macro. It drives the macro's BIST port (`A_BIST_*`) as the initiator: addresses, write data, byte mask, and write/read strobes. It runs a March C- sequence, checks every read against the expected background, and reports pass/fail with the first failing address and data. It sits beside the SRAM in the top-level wrapper, with its start and status bits mapped to spare user I/O.

## Interface
Parameters:
- `ADDR_W`, 10, SRAM address width; the test covers N = 2^ADDR_W words.
- `DATA_W`, 8, SRAM data width; the byte mask has the same width.

Ports:
- `clk`  in  1  single clock, same clock as `A_CLK`.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level-sampled; starts a test when sampled high in IDLE or DONE.
- `busy`  out  1  high while a test is running.
- `done`  out  1  high from test completion until the next start or reset.
- `fail`  out  1  valid with `done`; 1 means a mismatch was detected.
- `fail_addr`  out  ADDR_W  address of the first mismatch; 0 if none.
- `fail_data`  out  DATA_W  data read at the first mismatch.
- `fail_exp`  out  DATA_W  data expected at the first mismatch.
- `bist_en`  out  1  to `A_BIST_EN`; high while `busy`.
- `bist_men`  out  1  to `A_BIST_MEN`; high while ops are issued.
- `bist_wen`  out  1  to `A_BIST_WEN`.
- `bist_ren`  out  1  to `A_BIST_REN`.
- `bist_addr`  out  ADDR_W  to `A_BIST_ADDR`.
- `bist_din`  out  DATA_W  to `A_BIST_DIN`.
- `bist_bm`  out  DATA_W  to `A_BIST_BM`; all ones while ops are issued, 0 otherwise.
- `bist_dout`  in  DATA_W  from `A_DOUT`.

## Operation
- All outputs are registered. After reset every output is 0 and the state is IDLE.
- States:
  - IDLE
  - M0 ⇑(w B)
  - M1 ⇑(r B, w ~B)
  - M2 ⇑(r ~B, w B)
  - M3 ⇓(r B, w ~B)
  - M4 ⇓(r ~B, w B)
  - M5 ⇑(r B)
  - DRAIN
  - DONE
- B is the background word; B = 0x00 in the base build.
- ⇑ steps the address 0 to N-1; ⇓ steps N-1 to 0.
- Element ops per address:
  - Two-op elements: the read cycle precedes the write cycle at the same address.
  - Single-op elements: one cycle per address.
- An element ends after its last op at the final address. The next cycle issues the first op of the next element.
- M5 completes, then DRAIN for one cycle for the last compare, then DONE.
- Issuing ops: exactly one op per cycle, with exactly one of `bist_wen`/`bist_ren` high.
- Compare:
  - Each read registers its expected value and a "check pending" flag.
  - On the next cycle, `bist_dout` is compared to the expected value.
- First mismatch:
  - Latch `fail_addr`, `fail_data` and `fail_exp`, and set `fail`.
  - Go directly to DONE. The single op issued in the same cycle is harmless; no further ops are issued.
- DONE: `busy`=0, `done`=1, and the fail fields are held.
- `start` sampled high in DONE clears `done`, `fail` and the fail fields, then begins M0, as from IDLE.
- `start` is ignored while `busy`.
- `rst_n` low at any time, mid-test included:
  - Immediately returns to IDLE with all outputs 0.
  - The SRAM contents are then undefined, which is acceptable.

## Timing
- Edge E0 samples `start`=1. Op k (k = 0…) is driven after edge Ek and captured by the SRAM at edge Ek+1.
- SRAM read latency is one cycle: data for a read captured at Ek+1 is compared at Ek+2.
- Base test has 10N ops. Cycle timing:
  - `busy` is high after E0 through E10N+1.
  - `done` rises after E10N+1, i.e. 10N+1 cycles after start (10241 for N=1024).
- A failing run ends with `done`=1 after the edge where the compare is made.
- `bist_men`/`bist_bm` are high exactly during op cycles; they are low in DRAIN.

## Configuration
- Macro: `SRAM_BIST_CHECKERBOARD_EN`.
- Defined:
  - After M5 of pass 1 (B=0x00), pass 2 follows immediately with B=0x55 (~B=0xAA). There is no DRAIN or idle cycle between passes.
  - Pass 2 repeats the same M0..M5 sequence.
  - Total 20N ops; `done` rises after E20N+1.
  - `fail_exp` identifies which pass failed.
- Undefined: a single pass with B=0x00 only.

## Test plan
Bench setup: `ADDR_W`=4 (N=16) with a behavioral 1-cycle-read SRAM model.
- Fault-free memory, pulse `start` -> `done`=1 exactly 161 cycles after the start edge, `fail`=0, and `fail_addr`/`fail_data`/`fail_exp`=0. With the macro: 321 cycles.
- Bit 3 of address 5 stuck at 1 -> first failing read is M1 at address 5; `fail`=1, `fail_addr`=5, `fail_data`=0x08, `fail_exp`=0x00.
- Coupling fault where a write to address 9 flips bit 0 of address 2 -> failure flagged during M2 or M3 with `fail_addr`=2 and bit 0 differing.
- Assert `rst_n` low at cycle 50 of a run -> all outputs are 0 immediately. After release with no `start`, the block stays idle and `bist_men`=0.
- Pulse `start` during `busy` -> no effect and identical completion cycle. Pulse `start` in DONE after a failing run -> `fail` clears and a full run completes.
- Monitor every cycle -> `bist_wen` and `bist_ren` never both high; `bist_addr` order matches ⇑/⇓ per element; `bist_bm`=0xFF during ops.

Source files
------------

// File: rtl/sram_march_bist_if.sv
// ============================================================================
// sram_march_bist_if
// Start/status bits and SRAM BIST-port signals of the March C- BIST controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface sram_march_bist_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              start;
  logic              busy;
  logic              done;
  logic              fail;
  logic [ADDR_W-1:0] fail_addr;
  logic [DATA_W-1:0] fail_data;
  logic [DATA_W-1:0] fail_exp;
  logic              bist_en;
  logic              bist_men;
  logic              bist_wen;
  logic              bist_ren;
  logic [ADDR_W-1:0] bist_addr;
  logic [DATA_W-1:0] bist_din;
  logic [DATA_W-1:0] bist_bm;
  logic [DATA_W-1:0] bist_dout;

  modport master (
    input  start, bist_dout,
    output busy, done, fail, fail_addr, fail_data, fail_exp,
           bist_en, bist_men, bist_wen, bist_ren, bist_addr, bist_din, bist_bm
  );

  modport slave (
    output start, bist_dout,
    input  busy, done, fail, fail_addr, fail_data, fail_exp,
           bist_en, bist_men, bist_wen, bist_ren, bist_addr, bist_din, bist_bm
  );
endinterface

`default_nettype wire

// File: rtl/sram_march_bist.sv
// ============================================================================
// sram_march_bist
// March C- BIST controller for a 1-cycle-read single-port SRAM; reports the
// first failing address/data. Option macro: SRAM_BIST_CHECKERBOARD_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sram_march_bist #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  sram_march_bist_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_M0    = 4'd1,
    S_M1    = 4'd2,
    S_M2    = 4'd3,
    S_M3    = 4'd4,
    S_M4    = 4'd5,
    S_M5    = 4'd6,
    S_DRAIN = 4'd7,
    S_DONE  = 4'd8
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ph_q, ph_d;
  logic              pass_q, pass_d;
  logic              chk_q, chk_d;
  logic [ADDR_W-1:0] chk_addr_q, chk_addr_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fail_q, fail_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0] fail_data_q, fail_data_d;
  logic [DATA_W-1:0] fail_exp_q, fail_exp_d;
  logic              men_q, men_d;
  logic              wen_q, wen_d;
  logic              ren_q, ren_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [DATA_W-1:0] bm_q, bm_d;
  logic [DATA_W-1:0] bg_cur, bg_nxt;
  logic              up_w, two_op_w, last_w;

`ifdef SRAM_BIST_CHECKERBOARD_EN
  localparam logic [DATA_W-1:0] C_BG_ALT = DATA_W'({DATA_W{2'b01}});
  assign bg_cur = pass_q ? C_BG_ALT : '0;
  assign bg_nxt = pass_d ? C_BG_ALT : '0;
`else
  assign bg_cur = '0;
  assign bg_nxt = '0;
`endif

  function automatic logic is_march(input state_t s);
    return s inside {S_M0, S_M1, S_M2, S_M3, S_M4, S_M5};
  endfunction

  // ph selects the read (0) or write (1) half of a two-op element
  function automatic logic is_read(input state_t s, input logic ph);
    return (s == S_M5) || ((s inside {S_M1, S_M2, S_M3, S_M4}) && !ph);
  endfunction

  function automatic logic [DATA_W-1:0] op_data(input state_t s, input logic ph,
                                                input logic [DATA_W-1:0] bg);
    logic inv;
    inv = ((s == S_M1 || s == S_M3) && ph) || ((s == S_M2 || s == S_M4) && !ph);
    return inv ? ~bg : bg;
  endfunction

  assign up_w     = state_q inside {S_M0, S_M1, S_M2, S_M5};
  assign two_op_w = state_q inside {S_M1, S_M2, S_M3, S_M4};
  assign last_w   = up_w ? (addr_q == '1) : (addr_q == '0);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    ph_d        = ph_q;
    pass_d      = pass_q;
    chk_d       = 1'b0;
    chk_addr_d  = chk_addr_q;
    exp_d       = exp_q;
    done_d      = done_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    fail_exp_d  = fail_exp_q;

    if (men_q && ren_q) begin
      chk_d      = 1'b1;
      chk_addr_d = addr_q;
      exp_d      = op_data(state_q, ph_q, bg_cur);
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d     = S_M0;
          addr_d      = '0;
          ph_d        = 1'b0;
          pass_d      = 1'b0;
          done_d      = 1'b0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_data_d = '0;
          fail_exp_d  = '0;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      default: begin
        if (two_op_w && !ph_q) begin
          ph_d = 1'b1;
        end else begin
          ph_d = 1'b0;
          if (!last_w) begin
            addr_d = up_w ? addr_q + ADDR_W'(1) : addr_q - ADDR_W'(1);
          end else begin
            unique case (state_q)
              S_M0: begin state_d = S_M1; addr_d = '0; end
              S_M1: begin state_d = S_M2; addr_d = '0; end
              S_M2: begin state_d = S_M3; addr_d = '1; end
              S_M3: begin state_d = S_M4; addr_d = '1; end
              S_M4: begin state_d = S_M5; addr_d = '0; end
              default: begin
`ifdef SRAM_BIST_CHECKERBOARD_EN
                if (!pass_q) begin
                  state_d = S_M0;
                  addr_d  = '0;
                  pass_d  = 1'b1;
                end else begin
                  state_d = S_DRAIN;
                end
`else
                state_d = S_DRAIN;
`endif
              end
            endcase
          end
        end
      end
    endcase

    // first mismatch wins over sequencing and stops issuing ops
    if (chk_q && (bus.bist_dout != exp_q)) begin
      state_d     = S_DONE;
      done_d      = 1'b1;
      fail_d      = 1'b1;
      fail_addr_d = chk_addr_q;
      fail_data_d = bus.bist_dout;
      fail_exp_d  = exp_q;
      chk_d       = 1'b0;
    end

    busy_d = !(state_d inside {S_IDLE, S_DONE});
    men_d  = is_march(state_d);
    wen_d  = men_d && !is_read(state_d, ph_d);
    ren_d  = men_d && is_read(state_d, ph_d);
    din_d  = wen_d ? op_data(state_d, ph_d, bg_nxt) : '0;
    bm_d   = men_d ? '1 : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      ph_q        <= 1'b0;
      pass_q      <= 1'b0;
      chk_q       <= 1'b0;
      chk_addr_q  <= '0;
      exp_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      fail_exp_q  <= '0;
      men_q       <= 1'b0;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
      din_q       <= '0;
      bm_q        <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      ph_q        <= ph_d;
      pass_q      <= pass_d;
      chk_q       <= chk_d;
      chk_addr_q  <= chk_addr_d;
      exp_q       <= exp_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      fail_exp_q  <= fail_exp_d;
      men_q       <= men_d;
      wen_q       <= wen_d;
      ren_q       <= ren_d;
      din_q       <= din_d;
      bm_q        <= bm_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.fail      = fail_q;
  assign bus.fail_addr = fail_addr_q;
  assign bus.fail_data = fail_data_q;
  assign bus.fail_exp  = fail_exp_q;
  assign bus.bist_en   = busy_q;
  assign bus.bist_men  = men_q;
  assign bus.bist_wen  = wen_q;
  assign bus.bist_ren  = ren_q;
  assign bus.bist_addr = addr_q;
  assign bus.bist_din  = din_q;
  assign bus.bist_bm   = bm_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_march_bist.sv
// ============================================================================
// tb_sram_march_bist
// Bench for sram_march_bist with N=16 and a behavioural 1-cycle-read SRAM.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sram_march_bist;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int N      = 16;
`ifdef SRAM_BIST_CHECKERBOARD_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif
  localparam int OPS     = 10 * N * PASSES;
  localparam int RUN_CYC = OPS + 1;

  typedef struct packed {
    logic       wr;
    logic [3:0] addr;
    logic [7:0] data;
  } op_t;

  typedef struct {
    int         cyc;
    logic       fail;
    logic [3:0] fa;
    logic [7:0] fd;
    logic [7:0] fe;
    int         left;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_march_bist_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram_march_bist #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  // fault_mode 1: bit 3 of word 5 stuck at 1; 2: a value-changing write to 9 flips bit 0 of word 2
  logic [7:0] mem [N];
  int         fault_mode = 0;
  logic       mem_clr = 1'b0;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < N; i++) mem[i] <= 8'h00;
    end else if (bus.bist_men && bus.bist_wen) begin
      if (fault_mode == 1 && bus.bist_addr == 4'd5)
        mem[bus.bist_addr] <= ((mem[bus.bist_addr] & ~bus.bist_bm) | (bus.bist_din & bus.bist_bm)) | 8'h08;
      else
        mem[bus.bist_addr] <= (mem[bus.bist_addr] & ~bus.bist_bm) | (bus.bist_din & bus.bist_bm);
      if (fault_mode == 2 && bus.bist_addr == 4'd9 &&
          ((mem[9] & ~bus.bist_bm) | (bus.bist_din & bus.bist_bm)) != mem[9])
        mem[2] <= mem[2] ^ 8'h01;
    end
    if (bus.bist_men && bus.bist_ren) bus.bist_dout <= mem[bus.bist_addr];
  end

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   start_cyc = 0;
  op_t  opq [$];
  res_t resq [$];
  op_t  mo;
  res_t mr;
  logic done_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_op(input logic wr, input int a, input logic [7:0] d);
    op_t o;
    o.wr   = wr;
    o.addr = 4'(a);
    o.data = d;
    opq.push_back(o);
  endtask

  task automatic push_pass(input logic [7:0] b);
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < N; k++) begin
        int a;
        a = (e == 3 || e == 4) ? (N - 1 - k) : k;
        case (e)
          0: push_op(1'b1, a, b);
          1: begin push_op(1'b0, a, b);  push_op(1'b1, a, ~b); end
          2: begin push_op(1'b0, a, ~b); push_op(1'b1, a, b);  end
          3: begin push_op(1'b0, a, b);  push_op(1'b1, a, ~b); end
          4: begin push_op(1'b0, a, ~b); push_op(1'b1, a, b);  end
          default: push_op(1'b0, a, b);
        endcase
      end
    end
  endtask

  task automatic push_res(input int c, input logic f, input logic [3:0] fa,
                          input logic [7:0] fd, input logic [7:0] fe, input int left);
    res_t r;
    r.cyc = c; r.fail = f; r.fa = fa; r.fd = fd; r.fe = fe; r.left = left;
    resq.push_back(r);
  endtask

  task automatic start_run(input int fm);
    @(negedge clk);
    mem_clr    = 1'b1;
    fault_mode = fm;
    @(negedge clk);
    mem_clr = 1'b0;
    push_pass(8'h00);
`ifdef SRAM_BIST_CHECKERBOARD_EN
    push_pass(8'h55);
`endif
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    start_cyc = cyc;
    check("start_busy", bus.busy, 1);
    check("start_clear", {bus.done, bus.fail, bus.fail_addr, bus.fail_data, bus.fail_exp}, 0);
  endtask

  task automatic wait_done(input int limit);
    int i;
    i = 0;
    while (!bus.done && i < limit) begin
      @(negedge clk);
      i++;
    end
    check("done_timeout", bus.done, 1);
    @(negedge clk);
  endtask

  // monitor: per-op ordering against the queued op list, completion against queued results
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.bist_men) begin
        if (opq.size() == 0) begin
          check("op_unexpected", 1, 0);
        end else begin
          mo = opq.pop_front();
          check("op_kind", {bus.bist_wen, bus.bist_ren}, mo.wr ? 2'b10 : 2'b01);
          check("op_addr", bus.bist_addr, mo.addr);
          check("op_bm", bus.bist_bm, 8'hFF);
          if (mo.wr) check("op_din", bus.bist_din, mo.data);
        end
      end else begin
        check("idle_strobes", {bus.bist_bm, bus.bist_wen, bus.bist_ren}, 0);
      end
      if (bus.done && !done_prev) begin
        if (resq.size() == 0) begin
          check("done_unexpected", 1, 0);
        end else begin
          mr = resq.pop_front();
          check("done_cycle", cyc - start_cyc, mr.cyc);
          check("fail", bus.fail, mr.fail);
          check("fail_addr", bus.fail_addr, mr.fa);
          check("fail_data", bus.fail_data, mr.fd);
          check("fail_exp", bus.fail_exp, mr.fe);
          check("ops_left", opq.size(), mr.left);
          check("busy_at_done", bus.busy, 0);
          opq.delete();
        end
      end
    end
    done_prev = bus.done;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected bench to finish");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_status", {bus.busy, bus.done, bus.fail, bus.fail_addr, bus.fail_data, bus.fail_exp}, 0);
    check("rst_port", {bus.bist_en, bus.bist_men, bus.bist_wen, bus.bist_ren,
                       bus.bist_addr, bus.bist_din, bus.bist_bm}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // fault-free run
    push_res(RUN_CYC, 1'b0, 4'd0, 8'h00, 8'h00, 0);
    start_run(0);
    wait_done(RUN_CYC + 20);

    // stuck-at: M1 read of word 5 is op 26, compared 28 edges after start
    push_res(28, 1'b1, 4'd5, 8'h08, 8'h00, OPS - 28);
    start_run(1);
    wait_done(RUN_CYC + 20);

    // restart from DONE after a failure
    push_res(RUN_CYC, 1'b0, 4'd0, 8'h00, 8'h00, 0);
    start_run(0);
    wait_done(RUN_CYC + 20);

    // coupling: M2 read of word 2 is op 52, reads 0xFE against 0xFF
    push_res(54, 1'b1, 4'd2, 8'hFE, 8'hFF, OPS - 54);
    start_run(2);
    wait_done(RUN_CYC + 20);
    check("coupling_bit0", bus.fail_data ^ bus.fail_exp, 8'h01);

    // start while busy is ignored
    push_res(RUN_CYC, 1'b0, 4'd0, 8'h00, 8'h00, 0);
    start_run(0);
    repeat (30) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(RUN_CYC + 20);

    // reset mid-run
    start_run(0);
    repeat (49) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_status", {bus.busy, bus.done, bus.fail, bus.fail_addr, bus.fail_data, bus.fail_exp}, 0);
    check("midrst_port", {bus.bist_en, bus.bist_men, bus.bist_wen, bus.bist_ren,
                          bus.bist_addr, bus.bist_din, bus.bist_bm}, 0);
    opq.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_after_rst", {bus.bist_men, bus.busy, bus.done}, 0);
    end

    // recovery after reset
    push_res(RUN_CYC, 1'b0, 4'd0, 8'h00, 8'h00, 0);
    start_run(0);
    wait_done(RUN_CYC + 20);

    check("results_consumed", resq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
